// File: rtl/segre_pkg.sv
// Shared types and constants for the segre hazard controller and its scoreboard.
// SEGRE_WB_BYPASS_EN selects WB bypassing; without it, WB-distance hazards stall instead.
package segre_pkg;

    localparam int REG_SIZE  = 5;
    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        NO_BYPASS  = 2'd0,
        MEM_BYPASS = 2'd1,
        WB_BYPASS  = 2'd2
    } bypass_ex_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } hazard_state_e;

    typedef struct packed {
        logic                valid;
        logic [REG_SIZE-1:0] rd;
        logic                is_load;
    } sb_entry_t;

    // LU_EXTRA: stall cycles after the detection cycle of a load-use.
`ifdef SEGRE_WB_BYPASS_EN
    localparam int STALL_CNT_W = 1;
    localparam int LU_EXTRA    = 0;
`else
    localparam int STALL_CNT_W = 2;
    localparam int LU_EXTRA    = 1;
`endif

    function automatic logic src_hit(input sb_entry_t e, input logic used,
                                     input logic [REG_SIZE-1:0] addr);
        return used && (addr != '0) && e.valid && (e.rd == addr);
    endfunction

endpackage

// File: rtl/segre_scoreboard.sv
// Three-stage (EX, MEM, WB) destination scoreboard with per-source bypass resolution.
// Behaviour does not depend on SEGRE_WB_BYPASS_EN; the top filters the selects.
module segre_scoreboard
    import segre_pkg::*;
(
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                shift,
    input  logic                bubble,
    input  logic                mem_advance,
    input  logic                id_valid_i,
    input  logic [REG_SIZE-1:0] id_rd_addr_i,
    input  logic                id_rf_we_i,
    input  logic                id_is_load_i,
    input  logic                id_rs1_used_i,
    input  logic [REG_SIZE-1:0] id_rs1_addr_i,
    input  logic                id_rs2_used_i,
    input  logic [REG_SIZE-1:0] id_rs2_addr_i,
    output bypass_ex_sel_e      sel_a_o,
    output bypass_ex_sel_e      sel_b_o,
    output logic                lu_a_o,
    output logic                lu_b_o
);

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t id_entry;
    logic      use_a, use_b;

    assign use_a = id_valid_i && id_rs1_used_i;
    assign use_b = id_valid_i && id_rs2_used_i;

    always_comb begin
        id_entry         = '0;
        id_entry.valid   = id_valid_i && id_rf_we_i && (id_rd_addr_i != '0);
        id_entry.rd      = id_rd_addr_i;
        id_entry.is_load = id_is_load_i;
    end

    // Youngest producer wins; a WB hit needs no bypass because the RF is write-first.
    function automatic bypass_ex_sel_e resolve(input logic used, input logic [REG_SIZE-1:0] addr);
        if (src_hit(ex_q, used, addr))
            return ex_q.is_load ? NO_BYPASS : MEM_BYPASS;
        else if (src_hit(mem_q, used, addr))
            return WB_BYPASS;
        else if (src_hit(wb_q, used, addr))
            return NO_BYPASS;
        return NO_BYPASS;
    endfunction

    assign sel_a_o = resolve(use_a, id_rs1_addr_i);
    assign sel_b_o = resolve(use_b, id_rs2_addr_i);
    assign lu_a_o  = src_hit(ex_q, use_a, id_rs1_addr_i) && ex_q.is_load;
    assign lu_b_o  = src_hit(ex_q, use_b, id_rs2_addr_i) && ex_q.is_load;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (shift) begin
            ex_q  <= bubble ? '0 : id_entry;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end else if (mem_advance) begin
            wb_q        <= mem_q;
            mem_q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/segre_hazard_ctrl.sv
// Pipeline hazard controller: bypass selection, load-use stalls, redirect flush, memory wait.
// SEGRE_WB_BYPASS_EN enables WB bypassing; when undefined those cases stall until the producer is in WB.
// Handshake-free: all outputs are combinational from registered state and the current inputs.
module segre_hazard_ctrl
    import segre_pkg::*;
(
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                id_valid_i,
    input  logic [REG_SIZE-1:0] id_rs1_addr_i,
    input  logic [REG_SIZE-1:0] id_rs2_addr_i,
    input  logic                id_rs1_used_i,
    input  logic                id_rs2_used_i,
    input  logic [REG_SIZE-1:0] id_rd_addr_i,
    input  logic                id_rf_we_i,
    input  logic                id_is_load_i,
    input  logic                id_is_store_i,
    input  logic                ex_valid_i,
    input  logic                ex_tkbr_i,
    input  logic                ex_is_jaljalr_i,
    input  logic                mem_busy_i,
    output logic                block_id_o,
    output logic                block_ex_o,
    output logic                block_mem_o,
    output logic                inject_nops_o,
    output logic                kill_id_o,
    output bypass_ex_sel_e      mux_sel_a_o,
    output bypass_ex_sel_e      mux_sel_b_o,
    output bypass_ex_sel_e      mux_sel_load_o,
    output hazard_state_e       state_o
);

    hazard_state_e          state_q, saved_q, eff_state;
    logic [STALL_CNT_W-1:0] cnt_q;
    bypass_ex_sel_e         sb_sel_a, sb_sel_b, sel_a, sel_b;
    logic                   lu_a, lu_b, load_use, need_wb, hold, redirect;

    segre_scoreboard u_scoreboard (
        .clk_i         (clk_i),
        .rsn_i         (rsn_i),
        .shift         (!block_ex_o),
        .bubble        (inject_nops_o || block_id_o),
        .mem_advance   (!block_mem_o),
        .id_valid_i    (id_valid_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_rf_we_i    (id_rf_we_i),
        .id_is_load_i  (id_is_load_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .sel_a_o       (sb_sel_a),
        .sel_b_o       (sb_sel_b),
        .lu_a_o        (lu_a),
        .lu_b_o        (lu_b)
    );

    // MEM_WAIT behaves as the state it interrupted once mem_busy_i drops.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;
    assign redirect  = ex_valid_i && (ex_tkbr_i || ex_is_jaljalr_i);
    assign load_use  = lu_a || lu_b;
    assign hold      = (eff_state == STALL) && (cnt_q != '0);
    assign state_o   = state_q;

    always_comb begin
        sel_a   = sb_sel_a;
        sel_b   = sb_sel_b;
        need_wb = 1'b0;
`ifndef SEGRE_WB_BYPASS_EN
        need_wb = (sb_sel_a == WB_BYPASS) || (sb_sel_b == WB_BYPASS);
        if (sb_sel_a == WB_BYPASS) sel_a = NO_BYPASS;
        if (sb_sel_b == WB_BYPASS) sel_b = NO_BYPASS;
`endif
    end

    always_comb begin
        block_id_o    = 1'b0;
        block_ex_o    = 1'b0;
        block_mem_o   = 1'b0;
        inject_nops_o = 1'b0;
        kill_id_o     = 1'b0;
        if (!rsn_i) begin
            block_id_o = 1'b0;
        end else if (mem_busy_i) begin
            block_id_o  = 1'b1;
            block_ex_o  = 1'b1;
            block_mem_o = 1'b1;
        end else if (eff_state == FLUSH || redirect) begin
            kill_id_o     = 1'b1;
            inject_nops_o = 1'b1;
        end else if (load_use || need_wb || hold) begin
            block_id_o    = 1'b1;
            inject_nops_o = 1'b1;
        end
    end

    always_comb begin
        mux_sel_a_o    = NO_BYPASS;
        mux_sel_b_o    = NO_BYPASS;
        mux_sel_load_o = NO_BYPASS;
        if (rsn_i) begin
            mux_sel_a_o = sel_a;
            if (id_is_store_i) mux_sel_load_o = sel_b;
            else               mux_sel_b_o    = sel_b;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= RUN;
            saved_q <= RUN;
            cnt_q   <= '0;
        end else if (mem_busy_i) begin
            state_q <= MEM_WAIT;
            saved_q <= eff_state;
        end else begin
            case (eff_state)
                FLUSH: state_q <= RUN;
                default: begin
                    if (redirect) begin
                        state_q <= FLUSH;
                        cnt_q   <= '0;
                    end else if (load_use) begin
                        state_q <= STALL;
                        cnt_q   <= STALL_CNT_W'(LU_EXTRA);
                    end else if (hold) begin
                        state_q <= STALL;
                        cnt_q   <= cnt_q - 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// Self-checking bench for segre_hazard_ctrl: directed scenarios then random traffic,
// all compared against a history-queue model of the pipeline.
module tb_segre_hazard_ctrl;
    import segre_pkg::*;

`ifdef SEGRE_WB_BYPASS_EN
    localparam int LU_STALL = 1;
`else
    localparam int LU_STALL = 2;
`endif

    logic clk_i, rsn_i;
    logic id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rf_we_i, id_is_load_i, id_is_store_i;
    logic [REG_SIZE-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic ex_valid_i, ex_tkbr_i, ex_is_jaljalr_i, mem_busy_i;
    logic block_id_o, block_ex_o, block_mem_o, inject_nops_o, kill_id_o;
    bypass_ex_sel_e mux_sel_a_o, mux_sel_b_o, mux_sel_load_o;
    hazard_state_e state_o;

    segre_hazard_ctrl dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .id_rd_addr_i(id_rd_addr_i),
        .id_rf_we_i(id_rf_we_i), .id_is_load_i(id_is_load_i), .id_is_store_i(id_is_store_i),
        .ex_valid_i(ex_valid_i), .ex_tkbr_i(ex_tkbr_i), .ex_is_jaljalr_i(ex_is_jaljalr_i),
        .mem_busy_i(mem_busy_i),
        .block_id_o(block_id_o), .block_ex_o(block_ex_o), .block_mem_o(block_mem_o),
        .inject_nops_o(inject_nops_o), .kill_id_o(kill_id_o),
        .mux_sel_a_o(mux_sel_a_o), .mux_sel_b_o(mux_sel_b_o), .mux_sel_load_o(mux_sel_load_o),
        .state_o(state_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks, failures;

    // reference model: hist[0] is the instruction that left ID most recently (EX), then MEM, WB
    typedef struct { bit v; int rd; bit ld; } prod_t;
    prod_t hist[$];
    bit    m_flush;
    int    m_stall;
    int    n_kind; // 0 frozen, 1 bubble, 2 issue
    bit    n_flush;
    int    n_stall;
    prod_t n_entry;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prod_t e;
        e.v = 0; e.rd = 0; e.ld = 0;
        hist = {};
        for (int i = 0; i < 3; i++) hist.push_back(e);
        m_flush = 0;
        m_stall = 0;
    endtask

    function automatic int age_of(input logic used, input logic [REG_SIZE-1:0] addr);
        if (!(id_valid_i && used) || addr == 0) return -1;
        for (int i = 0; i < 3; i++)
            if (hist[i].v && hist[i].rd == int'(addr)) return i;
        return -1;
    endfunction

    function automatic bypass_ex_sel_e sel_of(input int age);
        if (age == 0) return MEM_BYPASS;
`ifdef SEGRE_WB_BYPASS_EN
        if (age == 1) return WB_BYPASS;
`endif
        return NO_BYPASS;
    endfunction

    task automatic model_check();
        int aa, ba;
        bit lu, wbn, issue;
        bit e_bid, e_bex, e_bmem, e_inj, e_kill;
        bit redirect;
        aa = age_of(id_rs1_used_i, id_rs1_addr_i);
        ba = age_of(id_rs2_used_i, id_rs2_addr_i);
        lu = ((aa == 0) || (ba == 0)) && hist[0].ld;
`ifdef SEGRE_WB_BYPASS_EN
        wbn = 0;
`else
        wbn = (aa == 1) || (ba == 1);
`endif
        redirect = ex_valid_i && (ex_tkbr_i || ex_is_jaljalr_i);
        {e_bid, e_bex, e_bmem, e_inj, e_kill, issue} = '0;
        n_flush = m_flush;
        n_stall = m_stall;
        n_kind  = 1;
        if (mem_busy_i) begin
            {e_bid, e_bex, e_bmem} = 3'b111;
            n_kind = 0;
        end else if (m_flush) begin
            {e_kill, e_inj} = 2'b11;
            n_flush = 0;
        end else if (redirect) begin
            {e_kill, e_inj} = 2'b11;
            n_flush = 1;
            n_stall = 0;
        end else if (lu || wbn || m_stall > 0) begin
            {e_bid, e_inj} = 2'b11;
            n_stall = lu ? LU_STALL - 1 : (m_stall > 0 ? m_stall - 1 : 0);
        end else begin
            issue  = 1;
            n_kind = 2;
        end
        n_entry.v  = id_valid_i && id_rf_we_i && (id_rd_addr_i != 0);
        n_entry.rd = id_rd_addr_i;
        n_entry.ld = id_is_load_i;
        chk("block_id", block_id_o, e_bid);
        chk("block_ex", block_ex_o, e_bex);
        chk("block_mem", block_mem_o, e_bmem);
        chk("inject", inject_nops_o, e_inj);
        chk("kill", kill_id_o, e_kill);
        if (issue) begin
            chk("sel_a", mux_sel_a_o, sel_of(aa));
            chk("sel_b", mux_sel_b_o, id_is_store_i ? NO_BYPASS : sel_of(ba));
            chk("sel_load", mux_sel_load_o, id_is_store_i ? sel_of(ba) : NO_BYPASS);
        end
    endtask

    task automatic model_update();
        prod_t e;
        if (n_kind == 0) return;
        e.v = 0; e.rd = 0; e.ld = 0;
        if (n_kind == 2) e = n_entry;
        hist.push_front(e);
        void'(hist.pop_back());
        m_flush = n_flush;
        m_stall = n_stall;
    endtask

    // driver tasks
    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit we, input bit ld, input bit st);
        id_valid_i    = v;
        id_rs1_addr_i = REG_SIZE'(rs1);
        id_rs1_used_i = u1;
        id_rs2_addr_i = REG_SIZE'(rs2);
        id_rs2_used_i = u2;
        id_rd_addr_i  = REG_SIZE'(rd);
        id_rf_we_i    = we;
        id_is_load_i  = ld;
        id_is_store_i = st;
    endtask

    task automatic set_ex(input bit v, input bit br, input bit jl, input bit busy);
        ex_valid_i      = v;
        ex_tkbr_i       = br;
        ex_is_jaljalr_i = jl;
        mem_busy_i      = busy;
    endtask

    task automatic sample();
        @(negedge clk_i);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_ex(0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin sample(); advance(); end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_block_id"}, block_id_o, 0);
        chk({tag, "_block_ex"}, block_ex_o, 0);
        chk({tag, "_block_mem"}, block_mem_o, 0);
        chk({tag, "_inject"}, inject_nops_o, 0);
        chk({tag, "_kill"}, kill_id_o, 0);
        chk({tag, "_sel_a"}, mux_sel_a_o, NO_BYPASS);
        chk({tag, "_sel_b"}, mux_sel_b_o, NO_BYPASS);
        chk({tag, "_sel_load"}, mux_sel_load_o, NO_BYPASS);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rsn_i = 1'b0;
        model_reset();
        // reset must override a busy memory and a redirect
        set_id(1, 1, 1, 2, 1, 3, 1, 0, 0);
        set_ex(1, 1, 0, 1);
        #2;
        chk_all_zero("reset");
        chk("reset_state", state_o, RUN);
        @(posedge clk_i); @(posedge clk_i); #1;
        rsn_i = 1'b1;
        idle(1);

        // add x5 ; add x6,x5,x1 -> EX bypass, no stall
        set_id(1, 1, 1, 2, 1, 5, 1, 0, 0); sample(); advance();
        set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); sample();
        chk("alu_fwd_sel_a", mux_sel_a_o, MEM_BYPASS);
        chk("alu_fwd_nostall", block_id_o, 0);
        advance();
        idle(3);

        // lw x5 ; sub x7,x1,x5 -> load-use
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); sample(); advance();
        set_id(1, 1, 1, 5, 1, 7, 1, 0, 0); sample();
        chk("lu_block", block_id_o, 1);
        chk("lu_inject", inject_nops_o, 1);
        advance();
`ifndef SEGRE_WB_BYPASS_EN
        sample();
        chk("lu_block2", block_id_o, 1);
        advance();
`endif
        sample();
        chk("lu_release", block_id_o, 0);
`ifdef SEGRE_WB_BYPASS_EN
        chk("lu_sel_b", mux_sel_b_o, WB_BYPASS);
`else
        chk("lu_sel_b", mux_sel_b_o, NO_BYPASS);
`endif
        advance();
        idle(3);

        // add x5 ; add x9 ; sw x5,0(x3) -> store data from WB distance
        set_id(1, 1, 1, 2, 1, 5, 1, 0, 0); sample(); advance();
        set_id(1, 1, 1, 2, 1, 9, 1, 0, 0); sample(); advance();
        set_id(1, 3, 1, 5, 1, 0, 0, 0, 1); sample();
`ifdef SEGRE_WB_BYPASS_EN
        chk("st_sel_load", mux_sel_load_o, WB_BYPASS);
`else
        chk("st_block", block_id_o, 1);
        advance();
        sample();
        chk("st_sel_load", mux_sel_load_o, NO_BYPASS);
`endif
        chk("st_sel_a", mux_sel_a_o, NO_BYPASS);
        chk("st_sel_b", mux_sel_b_o, NO_BYPASS);
        advance();
        idle(3);

        // lw x5 ; taken branch in EX with load-use in ID
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); sample(); advance();
        set_id(1, 1, 1, 5, 1, 7, 1, 0, 0);
        set_ex(1, 1, 0, 0); sample();
        chk("br_kill1", kill_id_o, 1);
        chk("br_inject1", inject_nops_o, 1);
        chk("br_noblock", block_id_o, 0);
        advance();
        set_ex(0, 0, 0, 0); sample();
        chk("br_kill2", kill_id_o, 1);
        chk("br_inject2", inject_nops_o, 1);
        chk("br_no_stall_state", state_o == STALL, 0);
        advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); sample();
        chk("br_done_kill", kill_id_o, 0);
        chk("br_done_state", state_o, RUN);
        advance();
        idle(3);

        // memory busy for 3 cycles with a taken branch waiting in EX
        set_ex(1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("busy_blocks", {block_id_o, block_ex_o, block_mem_o}, 3'b111);
            chk("busy_nokill", {kill_id_o, inject_nops_o}, 2'b00);
            advance();
        end
        set_ex(1, 1, 0, 0); sample();
        chk("busy_then_kill", kill_id_o, 1);
        chk("busy_then_inject", inject_nops_o, 1);
        advance();
        set_ex(0, 0, 0, 0); sample(); advance();
        idle(3);

        // reset pulse while stalled
        set_id(1, 1, 1, 0, 0, 5, 1, 1, 0); sample(); advance();
        set_id(1, 1, 1, 5, 1, 7, 1, 0, 0); sample(); advance();
        #2 rsn_i = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        chk("rst_mid_state", state_o, RUN);
        model_reset();
        rsn_i = 1'b1;
        sample();
        chk("rst_after_block", block_id_o, 0);
        chk("rst_after_sel_b", mux_sel_b_o, NO_BYPASS);
        advance();
        idle(3);

        // random traffic on a small register set to provoke dense hazards
        for (int n = 0; n < 600; n++) begin
            bit v, ld, st, we;
            v  = ($urandom_range(0, 9) < 8);
            we = ($urandom_range(0, 9) < 6);
            ld = we && ($urandom_range(0, 9) < 3);
            st = !we && ($urandom_range(0, 9) < 4);
            set_id(v, $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 3),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 3), we, ld, st);
            set_ex($urandom_range(0, 1), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
                   $urandom_range(0, 99) < 10);
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
